// File: rtl/score_updater.sv
// score_updater -- per-team score register for the basketball scoreboard.
//
// Applies +1/+2/+3 additions and undo subtractions from panel buttons,
// keeping the score within [0, MAX_SCORE]. Button rises are edge-detected
// and followed by a lockout and a wait-for-release, so that one press
// produces exactly one update.
//
// Optional feature: define SCORE_UPDATER_BCD_EN to add registered BCD
// digit outputs score_tens / score_units (valid only for MAX_SCORE <= 99).
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   clear       in   synchronous score clear (level), priority after rst
//   add_btn     in   add request level (already synchronized)
//   sub_btn     in   subtract/undo request level
//   pts[1:0]    in   point value 1..3 (0 is refused)
//   score[6:0]  out  current score, binary
//   updated     out  one-cycle pulse when score changed
//   rejected    out  one-cycle pulse when a request was refused
//   busy        out  high whenever the FSM is not idle
//   score_tens  out  BCD tens digit   (SCORE_UPDATER_BCD_EN only)
//   score_units out  BCD units digit  (SCORE_UPDATER_BCD_EN only)
module score_updater #(
    parameter int MAX_SCORE   = 99,
    parameter int LOCK_CYCLES = 4,
    parameter int LOCK_W      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       add_btn,
    input  logic       sub_btn,
    input  logic [1:0] pts,
    output logic [6:0] score,
    output logic       updated,
    output logic       rejected,
`ifdef SCORE_UPDATER_BCD_EN
    output logic [3:0] score_tens,
    output logic [3:0] score_units,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, APPLY, LOCKOUT, WAIT_REL} state_t;
    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_BAD} op_t;

    localparam logic [7:0]        MAX8     = 8'(MAX_SCORE);
    localparam logic [LOCK_W-1:0] LOCK_LD  = LOCK_W'(LOCK_CYCLES - 1);

    state_t            state, state_nx;
    op_t               op_r;
    logic [1:0]        pts_r;
    logic              add_q, sub_q;
    logic              add_rise, sub_rise;
    logic [LOCK_W-1:0] lock_cnt;
    logic [7:0]        sum_w;
    logic              add_ok, sub_ok;
    logic              upd_d, rej_d;

    assign add_rise = add_btn & ~add_q;
    assign sub_rise = sub_btn & ~sub_q;

    // ---------------------------------------------------------------
    // State register. clear parks the FSM in WAIT_REL so a still-held
    // button cannot re-trigger once the clear is released.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst)        state <= IDLE;
        else if (clear) state <= WAIT_REL;
        else            state <= state_nx;
    end

    // ---------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (add_rise || sub_rise) state_nx = APPLY;
            APPLY:    state_nx = LOCKOUT;
            LOCKOUT:  if (lock_cnt == '0) state_nx = WAIT_REL;
            WAIT_REL: if (!add_btn && !sub_btn) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Output / decision logic. The sum is formed at 8 bits so a score
    // near 127 cannot wrap past the bound check.
    // ---------------------------------------------------------------
    always_comb begin
        sum_w  = {1'b0, score} + {6'b0, pts_r};
        add_ok = (op_r == OP_ADD) && (pts_r != 2'd0) && (sum_w <= MAX8);
        sub_ok = (op_r == OP_SUB) && (pts_r != 2'd0) && (score >= {5'b0, pts_r});
        upd_d  = 1'b0;
        rej_d  = 1'b0;
        if (state == APPLY) begin
            upd_d = add_ok | sub_ok;
            rej_d = ~(add_ok | sub_ok);
        end
        busy = (state != IDLE);
    end

    // ---------------------------------------------------------------
    // Datapath: edge registers, request latch, score, pulses, lockout
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            add_q    <= 1'b0;
            sub_q    <= 1'b0;
            op_r     <= OP_ADD;
            pts_r    <= 2'd0;
            score    <= 7'd0;
            updated  <= 1'b0;
            rejected <= 1'b0;
            lock_cnt <= '0;
        end else begin
            add_q    <= add_btn;
            sub_q    <= sub_btn;
            // clear discards any apply happening in the same cycle
            updated  <= upd_d & ~clear;
            rejected <= rej_d & ~clear;

            if (state == IDLE && (add_rise || sub_rise)) begin
                if (add_rise && sub_rise) op_r <= OP_BAD;
                else if (add_rise)        op_r <= OP_ADD;
                else                      op_r <= OP_SUB;
                pts_r <= pts;
            end

            if (clear)
                score <= 7'd0;
            else if (state == APPLY && add_ok)
                score <= sum_w[6:0];
            else if (state == APPLY && sub_ok)
                score <= score - {5'b0, pts_r};

            if (state == APPLY)
                lock_cnt <= LOCK_LD;
            else if (state == LOCKOUT && lock_cnt != '0)
                lock_cnt <= lock_cnt - 1'b1;
        end
    end

`ifdef SCORE_UPDATER_BCD_EN
    // Digits trail score by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            score_tens  <= 4'd0;
            score_units <= 4'd0;
        end else begin
            score_tens  <= 4'(score / 7'd10);
            score_units <= 4'(score % 7'd10);
        end
    end
`endif

endmodule

// File: tb/tb_score_updater.sv
// Bench for score_updater: a table of button presses with expected scores,
// hand-written multi-cycle corner cases, and random presses checked against
// an arithmetic score model.
module tb_score_updater;

    localparam int MAXS = 99;
    localparam int LOCK = 4;

    logic       clk = 1'b0;
    logic       rst, clear, add_btn, sub_btn;
    logic [1:0] pts;
    logic [6:0] score;
    logic       updated, rejected, busy;
`ifdef SCORE_UPDATER_BCD_EN
    logic [3:0] score_tens, score_units;
`endif

    score_updater #(.MAX_SCORE(MAXS), .LOCK_CYCLES(LOCK), .LOCK_W(3)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .add_btn(add_btn), .sub_btn(sub_btn), .pts(pts),
        .score(score), .updated(updated), .rejected(rejected),
`ifdef SCORE_UPDATER_BCD_EN
        .score_tens(score_tens), .score_units(score_units),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int mscore = 0;   // reference score

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; clear = 1'b0; add_btn = 1'b0; sub_btn = 1'b0; pts = 2'd0;
        @(negedge clk);
        rst = 1'b0;
        mscore = 0;
    endtask

    // One complete press: op 0=add 1=sub 2=both. Button held for 'hold'
    // sampling edges, then released; waits until the block is idle again.
    // Checks pulse count, pulse timing (two cycles after the press) and
    // the resulting score against the model.
    task automatic press(input int op, input int p, input int hold,
                         input string tag, output int ok);
        int nupd = 0, nrej = 0, first = -1;
        logic [1:0] pv;
        pv = 2'(p);
        add_btn = (op != 1);
        sub_btn = (op != 0);
        pts     = pv;
        for (int c = 1; c <= hold + LOCK + 4; c++) begin
            @(negedge clk);
            if ((updated || rejected) && first < 0) first = c;
            nupd += int'(updated);
            nrej += int'(rejected);
            if (c == hold) begin
                add_btn = 1'b0;
                sub_btn = 1'b0;
            end
        end
        ok = 0;
        if (op == 0 && p != 0 && mscore + p <= MAXS) ok = 1;
        if (op == 1 && p != 0 && mscore >= p)        ok = 1;
        if (ok == 1) mscore = (op == 0) ? mscore + p : mscore - p;
        chk($sformatf("%s updated", tag),  nupd, ok);
        chk($sformatf("%s rejected", tag), nrej, 1 - ok);
        chk($sformatf("%s pulse_cycle", tag), first, 2);
        chk($sformatf("%s score", tag), int'(score), mscore);
        chk($sformatf("%s busy", tag), int'(busy), 0);
    endtask

    typedef struct {
        int op;
        int p;
        int hold;
        int exp_score;
        int exp_upd;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int ok, cnt, op, p;
        rst = 1'b1; clear = 1'b0; add_btn = 1'b0; sub_btn = 1'b0; pts = 2'd0;

        tbl[0] = '{0, 2, 10, 2, 1};   // long hold: single update
        tbl[1] = '{1, 1, 2,  1, 1};
        tbl[2] = '{1, 3, 1,  1, 0};   // would go below zero
        tbl[3] = '{1, 1, 3,  0, 1};
        tbl[4] = '{1, 1, 1,  0, 0};   // sub from zero
        tbl[5] = '{0, 0, 2,  0, 0};   // pts=0 invalid
        tbl[6] = '{2, 2, 2,  0, 0};   // both buttons together
        tbl[7] = '{0, 3, 1,  3, 1};

        // reset state
        do_reset();
        chk("reset score", int'(score), 0);
        chk("reset updated", int'(updated), 0);
        chk("reset rejected", int'(rejected), 0);
        chk("reset busy", int'(busy), 0);

        for (int i = 0; i < 8; i++) begin
            press(tbl[i].op, tbl[i].p, tbl[i].hold, $sformatf("vec%0d", i), ok);
            chk($sformatf("vec%0d table_score", i), int'(score), tbl[i].exp_score);
            chk($sformatf("vec%0d table_upd", i), ok, tbl[i].exp_upd);
        end

        // upper bound
        do_reset();
        for (int i = 0; i < 32; i++) press(0, 3, 1, "climb", ok);
        press(0, 2, 1, "to98", ok);
        chk("at 98", int'(score), 98);
        press(0, 1, 1, "to99", ok);
        chk("at 99", int'(score), 99);
        press(0, 1, 1, "over99", ok);
        chk("over99 refused", ok, 0);
        chk("stay 99", int'(score), 99);
        press(1, 2, 1, "to97", ok);
        press(0, 3, 2, "97plus3", ok);
        chk("97plus3 refused", ok, 0);
        chk("stay 97", int'(score), 97);

        // re-press during lockout is ignored until a full release
        cnt = 0;
        add_btn = 1'b1; pts = 2'd1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            cnt += int'(updated);
            if (c == 2)  add_btn = 1'b0;
            if (c == 3)  add_btn = 1'b1;
            if (c == 10) add_btn = 1'b0;
        end
        chk("lockout single update", cnt, 1);
        chk("lockout score", int'(score), 98);
        mscore = 98;
        press(0, 1, 2, "after_release", ok);
        chk("after_release score", int'(score), 99);

        // clear during APPLY wins
        do_reset();
        for (int i = 0; i < 13; i++) press(0, 3, 1, "to39", ok);
        press(0, 1, 1, "to40", ok);
        chk("at 40", int'(score), 40);
        add_btn = 1'b1; pts = 2'd3;
        @(negedge clk);            // APPLY cycle now in progress
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear score", int'(score), 0);
        chk("clear no update", int'(updated), 0);
        chk("clear busy", int'(busy), 1);
        add_btn = 1'b0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            cnt += int'(updated) + int'(rejected);
        end
        chk("clear no pulses", cnt, 0);
        chk("clear idle", int'(busy), 0);
        mscore = 0;

        // reset during LOCKOUT
        add_btn = 1'b1; pts = 2'd2;
        @(negedge clk);
        @(negedge clk);
        chk("pre-rst score", int'(score), 2);
        @(negedge clk);            // in LOCKOUT
        rst = 1'b1; add_btn = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk("rst lockout score", int'(score), 0);
        chk("rst lockout busy", int'(busy), 0);
        chk("rst lockout updated", int'(updated), 0);
        mscore = 0;

        // random presses against the arithmetic model
        do_reset();
        for (int i = 0; i < 80; i++) begin
            cnt = int'($urandom_range(0, 9));
            op  = (cnt < 6) ? 0 : (cnt < 9) ? 1 : 2;
            p   = int'($urandom_range(0, 3));
            press(op, p, int'($urandom_range(1, 6)), $sformatf("rnd%0d", i), ok);
            if (int'(score) > MAXS) chk("rnd bound", int'(score), MAXS);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/score_updater.md
Name: score_updater

Overview:
- Per-team score register for the basketball scoreboard. Applies +1/+2/+3 point additions and undo subtractions from panel buttons.
- Enforces both bounds. A subtraction is legal only when score >= pts. An addition is legal only when score + pts <= MAX_SCORE.
- Includes button edge detection and a lockout, so one press produces exactly one update.
- Sits between the push-button/switch inputs and the display decoders. Instantiated once per team.

Parameters:
- MAX_SCORE, 99, highest legal score. Must be <= 127.
- LOCK_CYCLES, 4, clock cycles spent in LOCKOUT after each apply or reject. Must be >= 1.
- LOCK_W, 3, width of the lockout counter. Must satisfy 2^LOCK_W > LOCK_CYCLES.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous score clear; level-sensitive; highest priority after rst.
- add_btn  input  1  add request, level. Inputs are already synchronized externally.
- sub_btn  input  1  subtract (undo) request, level.
- pts  input  2  point value; 1, 2 or 3 are valid; 0 is invalid.
- score  output  7  current score, binary.
- updated  output  1  one-cycle pulse when score changed due to an add or subtract.
- rejected  output  1  one-cycle pulse when a request was refused.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=1 at an edge):
  - score=0, updated=0, rejected=0, FSM=IDLE.
  - Edge registers add_q=0 and sub_q=0; lockout counter=0.
  - Reset mid-operation aborts any pending apply; no pulse is produced.
- Edge detection: add_rise = add_btn & ~add_q, and likewise sub_rise. add_q/sub_q are registered every cycle in all states.
- FSM states: IDLE, APPLY, LOCKOUT, WAIT_REL.
- IDLE:
  - On add_rise xor sub_rise: latch op (add/sub) and pts into op_r/pts_r, then go to APPLY.
  - On add_rise and sub_rise in the same cycle: go to APPLY with an invalid op, which produces a reject.
  - With no rise: stay in IDLE.
- APPLY (exactly one cycle):
  - Add: if pts_r != 0 and score + pts_r <= MAX_SCORE, score <= score + pts_r and updated=1. Otherwise rejected=1.
  - Sub: if pts_r != 0 and score >= pts_r, score <= score - pts_r and updated=1. Otherwise rejected=1.
  - The addition is evaluated at 8-bit width so it cannot wrap.
  - Next state is LOCKOUT, with the counter loaded to LOCK_CYCLES-1.
- LOCKOUT: decrement the counter each cycle; go to WAIT_REL when counter==0. Button edges are ignored here.
- WAIT_REL: go to IDLE when add_btn==0 and sub_btn==0. Otherwise stay.
- Latency:
  - First cycle with the button high = cycle n (rise detected, request latched).
  - APPLY = cycle n+1. The new score and the updated/rejected pulse are visible after the edge ending n+1, i.e. during cycle n+2.
- updated and rejected are registered. Each is high for exactly one cycle. They are mutually exclusive.
- clear=1:
  - score <= 0 and FSM <= WAIT_REL; no updated or rejected pulse.
  - If clear coincides with APPLY, clear wins and the apply is discarded.
- score never exceeds MAX_SCORE and never goes below 0 under any input sequence.
- busy = (state != IDLE), decoded combinationally from the state register.

Optional Feature:
- Macro SCORE_UPDATER_BCD_EN.
- When defined, adds two outputs:
  - score_tens (4 bits)
  - score_units (4 bits)
- Both are registered BCD digits of score, updated one cycle after score changes and reset to 0.
- Valid only while MAX_SCORE <= 99.
- When undefined, these ports and their logic are absent. The rest of the behaviour is identical either way.

Test Plan:
- Reset, then add_btn high with pts=2 held for 10 cycles -> score=2 in cycle n+2; one updated pulse; no second update while the button is held.
- score=1, press sub_btn with pts=3 -> rejected pulse in cycle n+2; score stays 1. Then sub with pts=1 -> score=0 and updated pulses.
- Drive score to 98, press add with pts=1 -> 99. Then add with pts=1 -> rejected, score 99. With MAX_SCORE=99, add pts=3 from 97 -> rejected, score 97.
- add_btn and sub_btn rise in the same cycle with pts=2 -> rejected, score unchanged. Also press add with pts=0 -> rejected.
- Second add press during LOCKOUT (released and re-pressed within 3 cycles) -> ignored; no second update. The button must be released before the next press is accepted.
- clear asserted in the APPLY cycle with score=40 and add pts=3 -> score=0; no updated pulse. Also rst asserted during LOCKOUT -> score=0, busy=0 on the next cycle.
